// File: rtl/buffer_ifid_queue.sv
// IF/ID instruction queue: a DEPTH-entry circular buffer of {nPC, IR} pairs
// between fetch and decode, with valid/ready handshaking on both sides and a
// flush that squashes every queued instruction on a redirect. State advances
// on the falling clock edge; the head is presented combinationally, so an
// entry pushed into an empty queue is visible half a cycle later, exactly
// like the old single-entry latch. DEPTH=1 reduces to that latch.
module buffer_ifid_queue #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] npc_if_i,
  input  logic [WIDTH-1:0] ir_if_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] npc_id_o,
  output logic [WIDTH-1:0] ir_id_o,
  output logic [CNT_W-1:0] count_o
);

  // A 1-bit pointer is kept for DEPTH=1 so the pointer logic stays uniform;
  // it simply never leaves zero.
  localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] npc_mem_q [DEPTH];
  logic [WIDTH-1:0] ir_mem_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic wr_en;

  // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Handshake status depends only on occupancy; a full queue never accepts
  // a new entry even if decode is popping on the same edge.
  always_comb begin
    in_ready_o  = (count_q < CNT_FULL);
    out_valid_o = (count_q != '0);
    count_o     = count_q;
    push        = in_valid_i & in_ready_o;
    pop         = out_valid_o & out_ready_i;
  end

  // Head of queue, or an all-zero bubble when empty so decode never sees
  // stale instruction words.
  always_comb begin
    npc_id_o = '0;
    ir_id_o  = '0;
    if (out_valid_o) begin
      npc_id_o = npc_mem_q[rd_ptr_q];
      ir_id_o  = ir_mem_q[rd_ptr_q];
    end
  end

  // Next pointer/occupancy; flush overrides any push or pop on the same edge.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        wr_en    = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, updated on the falling edge.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push, cleared only by reset
  // (a flush leaves old words in place because count hides them).
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        npc_mem_q[i] <= '0;
        ir_mem_q[i]  <= '0;
      end
    end else if (wr_en) begin
      npc_mem_q[wr_ptr_q] <= npc_if_i;
      ir_mem_q[wr_ptr_q]  <= ir_if_i;
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always_ff @(negedge clk_i) begin
    if (!rst_i) begin
      assert (count_q <= CNT_FULL)
        else $error("occupancy %0d exceeds DEPTH %0d", count_q, DEPTH);
    end
  end

endmodule

// File: tb/tb_buffer_ifid_queue.sv
// Bench for buffer_ifid_queue: DEPTH=1,2,3 instances share one stimulus
// stream. Each instance has a queue-based reference model that is compared
// against the DUT on every rising edge (state changes on the falling edge).
// Directed sequences on the DEPTH=2 instance pin the model to literal values.
module tb_buffer_ifid_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] npc_if = '0;
  logic [31:0] ir_if = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D  = g + 1;
    localparam int CW = $clog2(D + 1);

    logic          in_ready;
    logic          out_valid;
    logic [31:0]   npc_id;
    logic [31:0]   ir_id;
    logic [CW-1:0] count;

    logic [63:0]   mq[$];

    buffer_ifid_queue #(.WIDTH(32), .DEPTH(D)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .npc_if_i   (npc_if),
      .ir_if_i    (ir_if),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .npc_id_o   (npc_id),
      .ir_id_o    (ir_id),
      .count_o    (count)
    );

    // Reference FIFO: a bounded queue of {nPC, IR}.
    always @(negedge clk or posedge rst) begin
      if (rst) begin
        mq.delete();
      end else if (flush) begin
        mq.delete();
      end else begin
        automatic bit do_pop  = out_ready && (mq.size() > 0);
        automatic bit do_push = in_valid && (mq.size() < D);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({npc_if, ir_if});
      end
    end

    always @(posedge clk) begin
      automatic logic [63:0] head = (mq.size() > 0) ? mq[0] : 64'h0;
      check($sformatf("d%0d.count", D), 64'(count), 64'(mq.size()));
      check($sformatf("d%0d.out_valid", D), 64'(out_valid), 64'(mq.size() != 0));
      check($sformatf("d%0d.in_ready", D), 64'(in_ready), 64'(mq.size() < D));
      check($sformatf("d%0d.npc_id", D), 64'(npc_id), 64'(head[63:32]));
      check($sformatf("d%0d.ir_id", D), 64'(ir_id), 64'(head[31:0]));
    end
  end

  // Drive one falling edge worth of inputs, then settle just after that edge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] npc,
                      input logic [31:0] ir, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    npc_if    = npc;
    ir_if     = ir;
    out_ready = ordy;
    @(negedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".out_valid"}, 64'(g_dut[1].out_valid), 64'h0);
    check({tag, ".ir_id"}, 64'(g_dut[1].ir_id), 64'h0);
    check({tag, ".npc_id"}, 64'(g_dut[1].npc_id), 64'h0);
    check({tag, ".count"}, 64'(g_dut[1].count), 64'h0);
    check({tag, ".in_ready"}, 64'(g_dut[1].in_ready), 64'h1);
  endtask

  initial begin
    #2;
    check_idle("reset");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Fill DEPTH=2 with decode stalled; third push refused.
    step(0, 1, 32'h4, 32'h20080005, 0);
    check("fill1.out_valid", 64'(g_dut[1].out_valid), 64'h1);
    check("fill1.ir_id", 64'(g_dut[1].ir_id), 64'h20080005);
    check("fill1.npc_id", 64'(g_dut[1].npc_id), 64'h4);
    step(0, 1, 32'h8, 32'h20090007, 0);
    check("fill2.count", 64'(g_dut[1].count), 64'h2);
    check("fill2.in_ready", 64'(g_dut[1].in_ready), 64'h0);
    check("fill2.ir_id", 64'(g_dut[1].ir_id), 64'h20080005);
    step(0, 1, 32'hC, 32'h01095020, 0);
    check("full.count", 64'(g_dut[1].count), 64'h2);
    check("full.ir_id", 64'(g_dut[1].ir_id), 64'h20080005);

    // Drain.
    step(0, 0, 32'h0, 32'h0, 1);
    check("drain1.ir_id", 64'(g_dut[1].ir_id), 64'h20090007);
    check("drain1.count", 64'(g_dut[1].count), 64'h1);
    step(0, 0, 32'h0, 32'h0, 1);
    check_idle("drain2");

    // Asynchronous reset with two entries queued, between clock edges.
    step(0, 1, 32'h10, 32'hAAAA0001, 0);
    step(0, 1, 32'h14, 32'hAAAA0002, 0);
    check("prerst.count", 64'(g_dut[1].count), 64'h2);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Streaming: push and pop every edge, pointers wrap.
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 32'(4 * i), 32'(i), 1);
      check($sformatf("stream%0d.ir_id", i), 64'(g_dut[1].ir_id), 64'(i));
      check($sformatf("stream%0d.count", i), 64'(g_dut[1].count), 64'h1);
    end
    step(0, 0, 32'h0, 32'h0, 1);
    check_idle("streamend");

    // Flush beats a simultaneous push and pop.
    step(0, 1, 32'h20, 32'h11110001, 0);
    step(0, 1, 32'h24, 32'h11110002, 0);
    step(1, 1, 32'h28, 32'h11110003, 1);
    check("flush.count", 64'(g_dut[1].count), 64'h0);
    check("flush.out_valid", 64'(g_dut[1].out_valid), 64'h0);
    check("flush.ir_id", 64'(g_dut[1].ir_id), 64'h0);
    step(0, 1, 32'h30, 32'hAC0A0000, 0);
    check("postflush.ir_id", 64'(g_dut[1].ir_id), 64'hAC0A0000);
    check("postflush.count", 64'(g_dut[1].count), 64'h1);
    step(1, 0, 32'h0, 32'h0, 0);

    // Random traffic against the reference models.
    for (int n = 0; n < 1000; n++) begin
      step($urandom_range(99, 0) < 6,
           $urandom_range(99, 0) < 65,
           $urandom,
           $urandom,
           $urandom_range(99, 0) < 55);
    end

    step(0, 0, 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buffer_ifid_queue.md
Name: buffer_ifid_queue

Overview:
Parametrised IF/ID pipeline buffer that replaces the single-entry fetch/decode latch with a DEPTH-entry circular instruction queue. Each entry holds {nPC, IR}. The queue adds valid/ready handshaking, so fetch can run ahead while decode stalls, and a flush input squashes in-flight instructions on branch/jump redirect. It sits between the fetch stage and the decode stage. With DEPTH=1 it degenerates to a stallable, flushable IF/ID latch.

Parameters:
WIDTH, 32, bit width of nPC and IR fields (one machine word)
DEPTH, 2, number of queue entries; legal range 1..16
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clk  input  1  pipeline clock; all state updates on falling edge
reset  input  1  asynchronous, active-high; clears all state immediately
flush  input  1  squash all queued entries (branch/jump redirect)
in_valid  input  1  fetch presents a valid {nPC_if, IR_if}
in_ready  output  1  queue can accept an entry this cycle
nPC_if  input  WIDTH  next-PC from fetch
IR_if  input  WIDTH  instruction word from fetch
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle (0 = decode stall)
nPC_id  output  WIDTH  head entry next-PC
IR_id  output  WIDTH  head entry instruction
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, any time, including mid-operation): rd_ptr=0, wr_ptr=0, count=0, all storage entries zeroed. Outputs during and after reset: out_valid=0, nPC_id=0, IR_id=0, in_ready=1, count=0.
- State update occurs only on the falling edge of clk when reset=0.
- push = in_valid & in_ready; pop = out_valid & out_ready, both sampled at the falling edge.
- in_ready = (count < DEPTH), combinational from count only. There is no full-with-pop pass-through, and in_ready never depends on out_ready.
- out_valid = (count != 0).
- nPC_id/IR_id = storage[rd_ptr] when out_valid=1; forced to 0 (NOP) when empty. Decode therefore sees a bubble, never stale data.
- Latency: an entry pushed at falling edge N into an empty queue appears on nPC_id/IR_id, with out_valid=1, immediately after edge N. This is one half-cycle, the same as the single-entry latch.
- Push: storage[wr_ptr] <= {nPC_if, IR_if}, wr_ptr advances.
- Pop: rd_ptr advances.
- Push and pop on the same edge: both take effect and count is unchanged. This is legal only when 0 < count < DEPTH.
- Pointer wrap: after DEPTH-1, a pointer advances to 0. DEPTH need not be a power of two.
- Count: count +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH or goes below 0.
- Flush has priority. At an edge with flush=1, the queue ends with rd_ptr=wr_ptr=0 and count=0. push and pop at that edge are ignored, and storage contents need not be cleared. Immediately after the edge, out_valid=0 and IR_id=0.
- Flush while empty: no effect other than pointer reset.
- in_valid while full: entry not accepted. Fetch must hold its PC; the queue does not latch or drop it silently.
- out_ready while empty: ignored, no pointer movement.
- Inputs are not required to be stable between edges; only values at the falling edge matter.

Test Plan:
- Reset, then 0 edges with in_valid=0 -> out_valid=0, IR_id=0, nPC_id=0, count=0, in_ready=1. Assert reset mid-sequence with count=2 -> all outputs return to these values without waiting for a clock edge.
- DEPTH=2, out_ready=0; push IR=0x20080005/nPC=0x4, then IR=0x20090007/nPC=0x8 -> count=2, in_ready=0, IR_id=0x20080005. Third push of IR=0x01095020 is refused and count stays 2.
- From the full state, out_ready=1, in_valid=0 for two edges -> IR_id shows 0x20090007 then 0 (NOP), count goes 1 then 0.
- Streaming with in_valid=1 and out_ready=1 every edge, IRs 0x1..0x6 -> count holds at 1 after the first edge, outputs appear in order 0x1..0x6, and pointers wrap with no loss or duplication.
- count=2 with flush=1, in_valid=1 and out_ready=1 on the same edge -> count=0, out_valid=0, IR_id=0. The next edge with in_valid=1 and IR=0xAC0A0000 -> IR_id=0xAC0A0000, count=1.
- DEPTH=1 and DEPTH=3 builds with random in_valid/out_ready/flush (1000 edges) checked against a reference FIFO model -> outputs always match the model, count is never above DEPTH, and the first entry after any flush is the first push after that flush.
